// File: rtl/burst_rr_scheduler.sv
// rtl/burst_rr_scheduler.sv - round-robin burst scheduler onto one word-serial valid/ready stream
// Captures a WORDS-word burst from the granted requester and emits it highest word first.
module burst_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int WORDS = 4,
    parameter int DW    = 32,
    localparam int SW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WORDS*DW-1:0] req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW-1:0]             out_data,
    output logic                      out_last,
    output logic [SW-1:0]             out_src,
    output logic                      busy
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_next;

    logic [SW-1:0] ptr, win, cand, next_ptr;
    logic          found;
    logic          hs;
    logic [IW-1:0] idx;
    logic [DW-1:0] word_buf [WORDS];

    // Scan from ptr upward (wrapping) for the first pending requester.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = SW'((int'(ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign hs        = (state == SEND) && out_ready;
    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign next_ptr  = (out_src == SW'(N_REQ - 1)) ? '0 : out_src + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (found) state_next = SEND;
            SEND: if (out_ready && idx == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && found) begin
            for (int w = 0; w < WORDS; w++)
                word_buf[w] <= req_data[(int'(win) * WORDS + w) * DW +: DW];
        end
    end

    // out_data/out_last are registered so they hold their value outside SEND.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            idx      <= '0;
            out_src  <= '0;
            gnt      <= '0;
            out_data <= '0;
            out_last <= 1'b0;
        end else begin
            gnt <= '0;
            if (state == IDLE && found) begin
                idx      <= IW'(WORDS - 1);
                out_src  <= win;
                gnt      <= N_REQ'(1) << win;
                out_data <= req_data[(int'(win) * WORDS + WORDS - 1) * DW +: DW];
                out_last <= (WORDS == 1);
            end else if (hs) begin
                if (idx != '0) begin
                    idx      <= idx - 1'b1;
                    out_data <= word_buf[idx - 1'b1];
                    out_last <= (idx == IW'(1));
                end else begin
                    ptr <= next_ptr;
                end
            end
        end
    end
endmodule

// File: tb/tb_burst_rr_scheduler.sv
// tb/tb_burst_rr_scheduler.sv - self-checking bench for burst_rr_scheduler
module tb_burst_rr_scheduler;
    localparam int N_REQ = 4;
    localparam int WORDS = 4;
    localparam int DW    = 32;

    logic                      clk;
    logic                      reset;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*WORDS*DW-1:0] req_data;
    logic [N_REQ-1:0]          gnt;
    logic                      out_valid;
    logic                      out_ready;
    logic [DW-1:0]             out_data;
    logic                      out_last;
    logic [1:0]                out_src;
    logic                      busy;

    burst_rr_scheduler #(.N_REQ(N_REQ), .WORDS(WORDS), .DW(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_src(out_src), .busy(busy)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [1:0]    s;
    } exp_t;

    exp_t            exp_q [$];
    logic [N_REQ-1:0] gnt_q [$];
    int checks = 0;
    int errors = 0;
    int words_seen = 0;
    int gnt_seen = 0;
    int cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] wv(int src, int w, int tag);
        return DW'(tag * 65536 + src * 256 + w);
    endfunction

    task automatic set_data(int src, int tag);
        for (int w = 0; w < WORDS; w++)
            req_data[(src * WORDS + w) * DW +: DW] = wv(src, w, tag);
    endtask

    task automatic push_burst(int src, int tag);
        exp_t e;
        for (int w = WORDS - 1; w >= 0; w--) begin
            e.d = wv(src, w, tag);
            e.l = (w == 0);
            e.s = 2'(src);
            exp_q.push_back(e);
        end
        gnt_q.push_back(N_REQ'(1) << src);
    endtask

    // Scoreboard: pops expected words on each handshake and expected grants on each gnt pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (out_valid && out_ready) begin
                words_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got data=%h src=%0d, required none", out_data, out_src);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.d || out_last !== e.l || out_src !== e.s) begin
                        errors++;
                        $display("FAIL word: got data=%h last=%b src=%0d, required data=%h last=%b src=%0d",
                                 out_data, out_last, out_src, e.d, e.l, e.s);
                    end
                end
            end
            if (gnt !== '0) begin
                gnt_seen++;
                checks++;
                if (gnt_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_gnt: got gnt=%b, required 0000", gnt);
                end else if (gnt !== gnt_q[0]) begin
                    errors++;
                    $display("FAIL gnt: got gnt=%b, required %b", gnt, gnt_q.pop_front());
                end else begin
                    void'(gnt_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int src, output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (gnt[src] !== 1'b1 && lat < 20);
        checks++;
        if (gnt[src] !== 1'b1) begin
            errors++;
            $display("FAIL gnt_timeout: got gnt=%b, required bit %0d", gnt, src);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            step();
            n++;
        end
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0 || gnt_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drain: got words_left=%0d gnts_left=%0d busy=%b, required 0 0 0",
                     exp_q.size(), gnt_q.size(), busy);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
        gnt_q.delete();
    endtask

    task automatic test_reset();
        req = '0;
        req_data = '0;
        out_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (gnt !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
            out_src !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: got gnt=%b v=%b d=%h l=%b s=%0d busy=%b, required all 0",
                     gnt, out_valid, out_data, out_last, out_src, busy);
        end
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single_burst();
        int lat;
        set_data(1, 1);
        push_burst(1, 1);
        req = 4'b0010;
        wait_gnt(1, lat);
        req = '0;
        checks++;
        if (lat != 1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: got lat=%0d valid=%b, required 1 1", lat, out_valid);
        end
        step();
        checks++;
        if (gnt !== '0) begin
            errors++;
            $display("FAIL gnt_pulse: got gnt=%b, required 0000", gnt);
        end
        wait_drain();
    endtask

    task automatic test_round_robin();
        int lat, last_cyc, now;
        do_reset();
        for (int s = 0; s < N_REQ; s++) set_data(s, 2);
        for (int g = 0; g < 5; g++) push_burst(g % N_REQ, 2);
        req = 4'b1111;
        last_cyc = 0;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(g % N_REQ, lat);
            now = cyc;
            if (g > 0) begin
                checks++;
                if (now - last_cyc != WORDS + 1) begin
                    errors++;
                    $display("FAIL rr_spacing: got %0d cycles, required %0d", now - last_cyc, WORDS + 1);
                end
            end
            last_cyc = now;
        end
        req = '0;
        wait_drain();
    endtask

    task automatic test_backpressure();
        int lat, start;
        set_data(2, 3);
        push_burst(2, 3);
        start = words_seen;
        req = 4'b0100;
        wait_gnt(2, lat);
        req = '0;
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== wv(2, 2, 3) || out_last !== 1'b0 || out_src !== 2'd2) begin
                errors++;
                $display("FAIL backpressure_hold: got v=%b d=%h l=%b s=%0d, required 1 %h 0 2",
                         out_valid, out_data, out_last, out_src, wv(2, 2, 3));
            end
            step();
        end
        out_ready = 1'b1;
        wait_drain();
        checks++;
        if (words_seen - start != WORDS) begin
            errors++;
            $display("FAIL backpressure_count: got %0d words, required %0d", words_seen - start, WORDS);
        end
    endtask

    task automatic test_capture_isolation();
        int lat;
        set_data(3, 4);
        push_burst(3, 4);
        req = 4'b1000;
        wait_gnt(3, lat);
        set_data(3, 9);
        req = '0;
        wait_drain();
    endtask

    task automatic test_reset_mid_burst();
        int lat, start, n;
        set_data(1, 5);
        push_burst(1, 5);
        req = 4'b0010;
        wait_gnt(1, lat);
        req = '0;
        start = words_seen;
        n = 0;
        while (words_seen - start < 2 && n < 20) begin
            step();
            n++;
        end
        reset = 1'b1;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (gnt !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
            out_src !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got gnt=%b v=%b d=%h l=%b s=%0d busy=%b, required all 0",
                     gnt, out_valid, out_data, out_last, out_src, busy);
        end
        #1;
        reset = 1'b0;
        step();
        set_data(3, 6);
        push_burst(3, 6);
        start = words_seen;
        req = 4'b1000;
        wait_gnt(3, lat);
        req = '0;
        wait_drain();
        checks++;
        if (words_seen - start != WORDS) begin
            errors++;
            $display("FAIL post_reset_count: got %0d words, required %0d", words_seen - start, WORDS);
        end
    endtask

    task automatic test_dropped_request();
        int lat, g0;
        set_data(2, 7);
        set_data(0, 8);
        push_burst(2, 7);
        g0 = gnt_seen;
        req = 4'b0100;
        wait_gnt(2, lat);
        req = '0;
        step();
        req = 4'b0001;
        step();
        req = '0;
        wait_drain();
        checks++;
        if (gnt_seen - g0 != 1) begin
            errors++;
            $display("FAIL dropped_req: got %0d grants, required 1", gnt_seen - g0);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_backpressure();
        test_capture_isolation();
        test_reset_mid_burst();
        test_dropped_request();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
